rtc_bus_sequencer: RTL

- Sequences every access to the external RTC chip over its multiplexed address/data bus (A_D, CS, RD, WR, io_port).
- Arbitrates between two requesters:
  - port A: write requester, i.e. the programming/configuration path driven by the pushbuttons and PS2.
  - port B: read requester, i.e. the periodic refresh that fills the VGA and 7-segment time registers.
- Runs one transaction at a time: an address phase, a gap, then a data phase, with programmable cycle-count timing.

---
 rtl/rtc_bus_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rtc_bus_sequencer.sv
// Sequencer for the external RTC chip's multiplexed address/data bus.
// Arbitrates one write port (A) against one read port (B) and runs a single timed access at a time.
module rtc_bus_sequencer #(
   parameter int unsigned T_SU  = 2,
   parameter int unsigned T_PW  = 4,
   parameter int unsigned T_HD  = 2,
   parameter int unsigned T_GAP = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_req,
   input  logic [7:0] a_addr,
   input  logic [7:0] a_wdata,
   output logic       a_ack,
   output logic       a_done,
   input  logic       b_req,
   input  logic [7:0] b_addr,
   output logic       b_ack,
   output logic       b_done,
   output logic [7:0] b_rdata,
   output logic       busy,
   output logic       CS,
   output logic       RD,
   output logic       WR,
   output logic       A_D,
   inout  wire  [7:0] io_port,
   output logic [3:0] state_dbg
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_ADDR_SU = 4'd1;
   localparam logic [3:0] S_ADDR_PW = 4'd2;
   localparam logic [3:0] S_ADDR_HD = 4'd3;
   localparam logic [3:0] S_GAP     = 4'd4;
   localparam logic [3:0] S_DATA_SU = 4'd5;
   localparam logic [3:0] S_DATA_PW = 4'd6;
   localparam logic [3:0] S_DATA_HD = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;

   // The counter holds (cycles remaining - 1), so a state ends when it reads zero.
   localparam logic [7:0] SU_LD  = 8'(T_SU - 1);
   localparam logic [7:0] PW_LD  = 8'(T_PW - 1);
   localparam logic [7:0] HD_LD  = 8'(T_HD - 1);
   localparam logic [7:0] GAP_LD = 8'(T_GAP - 1);

   logic [3:0] state, nxt_state;
   logic [7:0] cnt, nxt_cnt;
   logic       last_a;
   logic       is_wr;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic       grant_a, grant_b;
   logic       cnt_last;
   logic       addr_phase, data_phase;
   logic       drive_en;
   logic [7:0] drive_val;

   assign cnt_last = (cnt == 8'd0);

   // Handshake: a request is a level held by the requester; in IDLE the sequencer
   // answers with a same-cycle 1-cycle ack, latches the request fields on that edge,
   // and the requester may drop or change them from the next cycle on.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == S_IDLE && !reset) begin
         if (a_req && (!b_req || !last_a)) grant_a = 1'b1;
         else if (b_req)                   grant_b = 1'b1;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt - 8'd1;
      case (state)
         S_IDLE: begin
            nxt_cnt = 8'd0;
            if (grant_a || grant_b) begin
               nxt_state = S_ADDR_SU;
               nxt_cnt   = SU_LD;
            end
         end
         S_ADDR_SU: if (cnt_last) begin nxt_state = S_ADDR_PW; nxt_cnt = PW_LD;  end
         S_ADDR_PW: if (cnt_last) begin nxt_state = S_ADDR_HD; nxt_cnt = HD_LD;  end
         S_ADDR_HD: if (cnt_last) begin nxt_state = S_GAP;     nxt_cnt = GAP_LD; end
         S_GAP:     if (cnt_last) begin nxt_state = S_DATA_SU; nxt_cnt = SU_LD;  end
         S_DATA_SU: if (cnt_last) begin nxt_state = S_DATA_PW; nxt_cnt = PW_LD;  end
         S_DATA_PW: if (cnt_last) begin nxt_state = S_DATA_HD; nxt_cnt = HD_LD;  end
         S_DATA_HD: if (cnt_last) begin nxt_state = S_DONE;    nxt_cnt = 8'd0;   end
         S_DONE: begin
            nxt_state = S_IDLE;
            nxt_cnt   = 8'd0;
         end
         default: begin
            nxt_state = S_IDLE;
            nxt_cnt   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= 8'd0;
         last_a  <= 1'b0;
         is_wr   <= 1'b0;
         addr_q  <= 8'd0;
         wdata_q <= 8'd0;
         b_rdata <= 8'd0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         if (grant_a) begin
            last_a  <= 1'b1;
            is_wr   <= 1'b1;
            addr_q  <= a_addr;
            wdata_q <= a_wdata;
         end else if (grant_b) begin
            last_a  <= 1'b0;
            is_wr   <= 1'b0;
            addr_q  <= b_addr;
         end
         if (state == S_DATA_PW && cnt_last && !is_wr) b_rdata <= io_port;
      end
   end

   assign addr_phase = (state == S_ADDR_SU) || (state == S_ADDR_PW) || (state == S_ADDR_HD);
   assign data_phase = (state == S_DATA_SU) || (state == S_DATA_PW) || (state == S_DATA_HD);

   assign a_ack     = grant_a;
   assign b_ack     = grant_b;
   assign a_done    = (state == S_DONE) && is_wr;
   assign b_done    = (state == S_DONE) && !is_wr;
   assign busy      = (state != S_IDLE);
   assign CS        = !(addr_phase || data_phase);
   assign A_D       = !addr_phase;
   assign WR        = !((state == S_ADDR_PW) || (state == S_DATA_PW && is_wr));
   assign RD        = !(state == S_DATA_PW && !is_wr);
   assign state_dbg = state;

   // The bus is released for the whole read data phase so the RTC can drive it.
   assign drive_en  = addr_phase || (data_phase && is_wr);
   assign drive_val = addr_phase ? addr_q : wdata_q;
   assign io_port   = drive_en ? drive_val : 8'hzz;

endmodule
